card_dealer: RTL
================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter CARD_W, default 4, width of a dealt card value; matches the `card value width consumed by hand controllers.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, non-zero reset value of the shuffle LFSR.
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 i_reset_n  input  1  reset, synchronous, active-low.
REQ-005 i_startRound  input  1  request the opening deal of four cards.
REQ-006 i_hitPlayer  input  1  request one card to the player hand.
REQ-007 i_hitDealer  input  1  request one card to the dealer hand.
REQ-008 o_addPlayerCard  output  1  one-cycle strobe; drives the player hand's add-card input.
REQ-009 o_addDealerCard  output  1  one-cycle strobe; drives the dealer hand's add-card input.
REQ-010 o_newCard  output  CARD_W  card value, valid only while either strobe is high.
REQ-011 o_cardIndex  output  6  deck position 0..51 of the card being strobed (suit = index/13, rank = index%13+1).
REQ-012 o_cardsRemaining  output  6  undealt cards in the deck, 0..52.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_reshuffled  output  1  one-cycle pulse when the deck is refilled.

Function
REQ-015 Deck state is a 52-bit used mask; bit i set means deck position i has been dealt.
REQ-016 A 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advances every cycle in every state; candidate = lfsr[5:0].
REQ-017 FSM states: IDLE, DRAW, EMIT.
REQ-018 IDLE: i_startRound has priority, then i_hitPlayer, then i_hitDealer; an accepted request moves to DRAW on the next edge; no request keeps IDLE.
REQ-019 Requests arriving while o_busy is high are ignored and are not queued.
REQ-020 Opening deal targets are, in order: player, dealer, player, dealer.
REQ-021 DRAW, deck not empty: candidate >= 52 or already used -> stay in DRAW.
REQ-022 DRAW, deck not empty: candidate < 52 and unused -> set its mask bit, decrement o_cardsRemaining, latch index and value, go to EMIT.
REQ-023 DRAW, deck empty (o_cardsRemaining == 0): spend one cycle clearing the mask, set o_cardsRemaining to 52, pulse o_reshuffled, stay in DRAW.
REQ-024 Card value = rank if rank <= 10, else 10; ace = 1; values outside 1..10 are never emitted.
REQ-025 EMIT lasts exactly one cycle: the strobe for the current target is high, o_newCard and o_cardIndex are valid, and the other strobe is low.
REQ-026 EMIT exit: opening deal with fewer than 4 cards emitted -> DRAW with the next target; otherwise -> IDLE.
REQ-027 Both strobes are never high in the same cycle; every strobe comes from its own EMIT cycle, so consecutive strobes are at least 2 cycles apart.
REQ-028 Minimum latency from request accepted in IDLE to strobe is 2 cycles.
REQ-029 o_newCard and o_cardIndex hold their last value outside EMIT.
REQ-030 Only reset and REQ-023 refill the deck; ending a round does not.

Reset
REQ-031 With i_reset_n low at an edge, in any state: FSM = IDLE, mask cleared, o_cardsRemaining = 52, LFSR = LFSR_SEED, opening-deal counter = 0.
REQ-032 Same reset: o_addPlayerCard = 0, o_addDealerCard = 0, o_busy = 0, o_reshuffled = 0, o_newCard = 0, o_cardIndex = 0.
REQ-033 Reset overrides any request sampled at the same edge.
REQ-034 A reset mid-DRAW or mid-EMIT produces no strobe on or after the reset edge.

Verification
REQ-035 Reset, then idle 5 cycles -> o_cardsRemaining = 52, o_busy = 0, both strobes 0.
REQ-036 Pulse i_startRound -> exactly 4 strobes in order player, dealer, player, dealer; o_cardsRemaining = 48; o_busy drops after the 4th EMIT; each o_newCard in 1..10.
REQ-037 52 successive i_hitPlayer requests, each issued when o_busy = 0 -> 52 distinct o_cardIndex values 0..51; o_cardsRemaining = 0.
REQ-038 Then a 53rd hit -> one o_reshuffled pulse, o_cardsRemaining reads 51 after EMIT, one player strobe.
REQ-039 i_hitPlayer and i_hitDealer high in the same cycle in IDLE -> one player strobe only.
REQ-040 i_hitDealer pulsed during an opening deal -> ignored; exactly 4 strobes.
REQ-041 Two resets with the same LFSR_SEED and identical stimulus -> identical o_cardIndex sequences.
REQ-042 i_reset_n low in the cycle after a hit is accepted -> no strobe; o_cardsRemaining = 52.

Source files
------------

// File: rtl/card_dealer.sv
// Card dealer for a blackjack table: draws unused deck positions via a free-running LFSR
// and strobes each card to the player or dealer hand controller.
module card_dealer #(
  parameter int unsigned CARD_W    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_startRound,
  input  logic              i_hitPlayer,
  input  logic              i_hitDealer,
  output logic              o_addPlayerCard,
  output logic              o_addDealerCard,
  output logic [CARD_W-1:0] o_newCard,
  output logic [5:0]        o_cardIndex,
  output logic [5:0]        o_cardsRemaining,
  output logic              o_busy,
  output logic              o_reshuffled
);

  localparam logic [5:0] DeckSize = 6'd52;

  typedef enum logic [1:0] {StIdle, StDraw, StEmit} state_e;

  state_e            r_state, w_state_next;
  logic [15:0]       r_lfsr;
  logic [51:0]       r_mask;
  logic [5:0]        r_remaining;
  logic [1:0]        r_deal_cnt;
  logic              r_opening;
  logic              r_target;     // 0: player, 1: dealer
  logic [CARD_W-1:0] r_new_card;
  logic [5:0]        r_card_index;
  logic              r_reshuffled;

  logic              w_lfsr_fb;
  logic [5:0]        w_cand;
  logic [63:0]       w_mask_ext;
  logic              w_cand_free;
  logic              w_deck_empty;
  logic [3:0]        w_rank;
  logic [3:0]        w_value;
  logic [51:0]       w_pick;
  logic              w_any_req;

  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand       = r_lfsr[5:0];
  // Positions 52..63 do not exist; padding them as used rejects them for free.
  assign w_mask_ext   = {12'hFFF, r_mask};
  assign w_cand_free  = ~w_mask_ext[w_cand];
  assign w_deck_empty = (r_remaining == 6'd0);
  assign w_rank       = 4'(w_cand % 6'd13) + 4'd1;
  assign w_value      = (w_rank > 4'd10) ? 4'd10 : w_rank;
  assign w_pick       = 52'd1 << w_cand;
  assign w_any_req    = i_startRound | i_hitPlayer | i_hitDealer;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_any_req) w_state_next = StDraw;
      StDraw: if (!w_deck_empty && w_cand_free) w_state_next = StEmit;
      StEmit: w_state_next = (r_opening && r_deal_cnt != 2'd3) ? StDraw : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_lfsr       <= LFSR_SEED;
      r_mask       <= '0;
      r_remaining  <= DeckSize;
      r_deal_cnt   <= 2'd0;
      r_opening    <= 1'b0;
      r_target     <= 1'b0;
      r_new_card   <= '0;
      r_card_index <= 6'd0;
      r_reshuffled <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
      r_reshuffled <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_startRound) begin
            r_opening  <= 1'b1;
            r_target   <= 1'b0;
            r_deal_cnt <= 2'd0;
          end else if (i_hitPlayer) begin
            r_opening <= 1'b0;
            r_target  <= 1'b0;
          end else if (i_hitDealer) begin
            r_opening <= 1'b0;
            r_target  <= 1'b1;
          end
        end
        StDraw: begin
          if (w_deck_empty) begin
            r_mask       <= '0;
            r_remaining  <= DeckSize;
            r_reshuffled <= 1'b1;
          end else if (w_cand_free) begin
            r_mask       <= r_mask | w_pick;
            r_remaining  <= r_remaining - 6'd1;
            r_card_index <= w_cand;
            r_new_card   <= CARD_W'(w_value);
          end
        end
        StEmit: begin
          if (r_opening) begin
            if (r_deal_cnt == 2'd3) begin
              r_opening  <= 1'b0;
              r_deal_cnt <= 2'd0;
            end else begin
              r_deal_cnt <= r_deal_cnt + 2'd1;
              r_target   <= ~r_target;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy          = (r_state != StIdle);
    o_addPlayerCard = (r_state == StEmit) && !r_target;
    o_addDealerCard = (r_state == StEmit) && r_target;
  end

  assign o_newCard        = r_new_card;
  assign o_cardIndex      = r_card_index;
  assign o_cardsRemaining = r_remaining;
  assign o_reshuffled     = r_reshuffled;

endmodule
